serial_adder_nbit: RTL

Parametrised multi-cycle adder/subtractor, the sequential successor to the 1-bit full adder cell. It accepts two WIDTH-bit operands on a start pulse and processes DIGIT bits per clock through a carry register. It reports sum, carry-out and signed overflow with a busy/done handshake. It sits in the datapath library as the area-cheap alternative to a full-width combinational adder.

---
 rtl/serial_adder_nbit_pkg.sv | 15 +
 rtl/serial_adder_nbit_if.sv | 26 ++
 rtl/serial_adder_nbit_slice.sv | 40 ++++
 rtl/serial_adder_nbit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/serial_adder_nbit_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM states and
// the digit-count helper used to size the iteration counter.
package serial_adder_nbit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_adder_nbit_if.sv
// Request/result bundle of the serial adder; the requester drives the
// operands and start, the adder returns busy/done and the registered result.
interface serial_adder_nbit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_nbit_slice.sv
// DIGIT-bit ripple adder slice built from 1-bit full adder cells; it also
// exposes the carry entering its top bit so the caller can derive overflow.
module full_adder_1_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ctop
);
  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder_1_bit u_fa (
      .i_a   (i_a[i]),
      .i_b   (i_b[i]),
      .i_cin (w_c[i]),
      .o_sum (o_sum[i]),
      .o_cout(w_c[i+1])
    );
  end

  assign o_cout = w_c[DIGIT];
  assign o_ctop = w_c[DIGIT-1];
endmodule

// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder/subtractor: operands are consumed DIGIT bits per clock,
// LSB first, through a carry register; results load on the last digit.
module serial_adder_nbit
  import serial_adder_nbit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_nbit_if.slave bus
);
  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_ctop;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .i_a   (r_a[DIGIT-1:0]),
    .i_b   (r_b[DIGIT-1:0]),
    .i_cin (r_carry),
    .o_sum (w_slice_sum),
    .o_cout(w_slice_cout),
    .o_ctop(w_slice_ctop)
  );

  assign w_last    = (r_cnt == CW'(N - 1));
  // New digits enter at the MSB end so the accumulator is aligned after N steps
  assign w_acc_nxt = (r_acc >> DIGIT) | (WIDTH'(w_slice_sum) << (WIDTH - DIGIT));

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
          w_finish    = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with busy/done registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Operand shift registers, carry, accumulator and digit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= bus.b ^ {WIDTH{bus.sub}};
      r_acc   <= '0;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_nxt;
      r_carry <= w_slice_cout;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Result registers change only on the completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_finish) begin
      r_sum  <= w_acc_nxt;
      r_cout <= w_slice_cout;
      r_ovf  <= w_slice_ctop ^ w_slice_cout;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;
endmodule
